// File: rtl/mux_rr_arb_nxw_if.sv
// Bundle for the N-way selector: per-channel request/data/accept toward the producers,
// and a single registered valid/ready word toward the consumer.
interface mux_rr_arb_nxw_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                       mode;
  logic [SEL_W-1:0]           sel;
  logic [CHANNELS-1:0]        in_valid;
  logic [CHANNELS*WIDTH-1:0]  in_data;
  logic [CHANNELS-1:0]        in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_chan;

  // Producer/consumer side: drives requests and the output accept.
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  // Selector side.
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/mux_rr_arb_nxw.sv
// N-way selector (fixed select or round-robin) into one output register; 1 cycle accept-to-valid.
// Backpressure: a held word blocks all accepts (in_ready=0) until out_ready; drain and load may coincide.
module mux_rr_arb_nxw #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_arb_nxw_if.slave    bus
);

  logic [WIDTH-1:0]    chData [CHANNELS];
  logic                loadEn;
  logic                grantVld;
  logic [SEL_W-1:0]    grantIdx;
  logic [SEL_W-1:0]    rrIdx;
  logic                xfer;
  logic [CHANNELS-1:0] inReady;

  logic [SEL_W-1:0]    ptr;
  logic                outValid;
  logic [WIDTH-1:0]    outData;
  logic [SEL_W-1:0]    outChan;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign chData[c] = bus.in_data[c*WIDTH +: WIDTH];
  end

  assign loadEn = !outValid || bus.out_ready;

  // Round-robin search visits ptr+1 .. ptr (wrapping), first requester wins.
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    rrIdx    = ptr;
    if (!bus.mode) begin
      if ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS)) begin
        if (bus.in_valid[bus.sel]) begin
          grantVld = 1'b1;
          grantIdx = bus.sel;
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        rrIdx = (rrIdx == SEL_W'(CHANNELS-1)) ? '0 : rrIdx + 1'b1;
        if (!grantVld && bus.in_valid[rrIdx]) begin
          grantVld = 1'b1;
          grantIdx = rrIdx;
        end
      end
    end
  end

  always_comb begin
    inReady = '0;
    if (!rst && loadEn && grantVld) begin
      inReady[grantIdx] = 1'b1;
    end
  end

  assign xfer = |(inReady & bus.in_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outData  <= '0;
      outChan  <= '0;
      ptr      <= SEL_W'(CHANNELS-1);
    end else if (loadEn) begin
      if (xfer) begin
        outValid <= 1'b1;
        outData  <= chData[grantIdx];
        outChan  <= grantIdx;
        if (bus.mode) begin
          ptr <= grantIdx;
        end
      end else begin
        // Drained with nothing to replace it: data/chan keep their last values.
        outValid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign bus.out_chan  = outChan;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(inReady));

endmodule
